// File: rtl/ac_power_sequencer.sv
// AC power sequencer: delays economy-mode shutdowns by a grace period and enforces
// a compressor-protection lockout after every power-off.
module ac_power_sequencer #(
    parameter int unsigned GRACE_CYCLES   = 16,
    parameter int unsigned MIN_OFF_CYCLES = 32,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned SHUT_CNT_W     = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ac_enable_i,
    input  logic                  close_ac_i,
    output logic                  ac_on_o,
    output logic                  grace_active_o,
    output logic                  lockout_o,
    output logic                  eco_shutdown_o,
    output logic [SHUT_CNT_W-1:0] shutdown_count_o
);

    typedef enum logic [1:0] {
        StOff,
        StRun,
        StGrace,
        StLockout
    } state_e;

    localparam logic [CNT_W-1:0] GraceLast  = CNT_W'(GRACE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LockLast   = CNT_W'(MIN_OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimerOne   = CNT_W'(1);
    localparam logic [SHUT_CNT_W-1:0] CntOne = SHUT_CNT_W'(1);

    state_e                r_state, w_state_d;
    logic [CNT_W-1:0]      r_timer, w_timer_d;
    logic                  r_eco, w_eco_d;
    logic [SHUT_CNT_W-1:0] r_count, w_count_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= StOff;
            r_timer <= '0;
            r_eco   <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_d;
            r_timer <= w_timer_d;
            r_eco   <= w_eco_d;
            r_count <= w_count_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_timer_d = r_timer;
        w_eco_d   = 1'b0;
        w_count_d = r_count;
        unique case (r_state)
            StOff: begin
                if (ac_enable_i && !close_ac_i) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                if (!ac_enable_i) begin
                    w_state_d = StLockout;
                    w_timer_d = '0;
                end else if (close_ac_i) begin
                    w_state_d = StGrace;
                    w_timer_d = '0;
                end
            end
            StGrace: begin
                // User-off wins over eco expiry so a simultaneous drop is not counted.
                if (!ac_enable_i) begin
                    w_state_d = StLockout;
                    w_timer_d = '0;
                end else if (!close_ac_i) begin
                    w_state_d = StRun;
                    w_timer_d = '0;
                end else if (r_timer == GraceLast) begin
                    w_state_d = StLockout;
                    w_timer_d = '0;
                    w_eco_d   = 1'b1;
                    if (r_count != '1) begin
                        w_count_d = r_count + CntOne;
                    end
                end else begin
                    w_timer_d = r_timer + TimerOne;
                end
            end
            StLockout: begin
                if (r_timer == LockLast) begin
                    w_state_d = StOff;
                    w_timer_d = '0;
                end else begin
                    w_timer_d = r_timer + TimerOne;
                end
            end
            default: begin
                w_state_d = StOff;
                w_timer_d = '0;
            end
        endcase
    end

    assign ac_on_o          = (r_state == StRun) || (r_state == StGrace);
    assign grace_active_o   = (r_state == StGrace);
    assign lockout_o        = (r_state == StLockout);
    assign eco_shutdown_o   = r_eco;
    assign shutdown_count_o = r_count;

endmodule

// File: tb/tb_ac_power_sequencer.sv
// Self-checking bench for ac_power_sequencer: table-driven cycle vectors plus a
// saturation sequence for the shutdown counter.
module tb_ac_power_sequencer;

    localparam int unsigned GRACE  = 16;
    localparam int unsigned MINOFF = 32;
    localparam int unsigned CW     = 8;
    localparam int unsigned SW     = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          close = 1'b0;
    logic          ac_on, grace, lock, eco;
    logic [SW-1:0] cnt;

    ac_power_sequencer #(
        .GRACE_CYCLES  (GRACE),
        .MIN_OFF_CYCLES(MINOFF),
        .CNT_W         (CW),
        .SHUT_CNT_W    (SW)
    ) u_dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .ac_enable_i     (en),
        .close_ac_i      (close),
        .ac_on_o         (ac_on),
        .grace_active_o  (grace),
        .lockout_o       (lock),
        .eco_shutdown_o  (eco),
        .shutdown_count_o(cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic          en;
        logic          close;
        int            n;
        logic          ac;
        logic          grace;
        logic          lock;
        logic          eco;
        logic [SW-1:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input logic r, input logic e, input logic c, input int n,
                       input logic a, input logic g, input logic l, input logic p,
                       input logic [SW-1:0] k);
        vec_t v;
        v.rst_n = r; v.en = e; v.close = c; v.n = n;
        v.ac = a; v.grace = g; v.lock = l; v.eco = p; v.cnt = k;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [SW+3:0] act, input logic [SW+3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {ac,grace,lock,eco,cnt}=%b_%0d required %b_%0d at %0t",
                     name, act[SW+3:SW], act[SW-1:0], exp[SW+3:SW], exp[SW-1:0], $time);
        end
    endtask

    function automatic logic [SW+3:0] obs();
        return {ac_on, grace, lock, eco, cnt};
    endfunction

    initial begin
        logic [SW-1:0] exp_cnt;

        // rst, en, close, cycles, ac, grace, lock, eco, count
        add(0, 1, 0, 2,  0, 0, 0, 0, 0);  // reset with enable held
        add(1, 1, 0, 1,  1, 0, 0, 0, 0);  // OFF->RUN in one edge
        add(1, 1, 1, 16, 1, 1, 0, 0, 0);  // grace for 16 cycles
        add(1, 1, 1, 1,  0, 0, 1, 1, 1);  // eco shutdown pulse
        add(1, 1, 1, 31, 0, 0, 1, 0, 1);  // rest of lockout, pulse gone
        add(1, 1, 0, 1,  0, 0, 0, 0, 1);  // OFF exactly 32 edges later
        add(1, 1, 0, 1,  1, 0, 0, 0, 1);  // RUN
        add(1, 1, 1, 10, 1, 1, 0, 0, 1);  // partial grace
        add(1, 1, 0, 3,  1, 0, 0, 0, 1);  // aborted, AC stays on
        add(1, 1, 1, 5,  1, 1, 0, 0, 1);  // grace again
        add(1, 0, 0, 1,  0, 0, 1, 0, 1);  // both drop: user-off, no pulse
        add(1, 1, 0, 10, 0, 0, 1, 0, 1);  // lockout ignores inputs
        add(1, 0, 1, 10, 0, 0, 1, 0, 1);
        add(1, 1, 0, 11, 0, 0, 1, 0, 1);
        add(1, 1, 0, 1,  0, 0, 0, 0, 1);  // OFF 32 edges after entry
        add(1, 1, 0, 1,  1, 0, 0, 0, 1);
        add(1, 1, 1, 16, 1, 1, 0, 0, 1);
        add(1, 1, 1, 1,  0, 0, 1, 1, 2);
        add(1, 1, 1, 5,  0, 0, 1, 0, 2);
        add(0, 1, 0, 1,  0, 0, 0, 0, 0);  // reset mid-lockout
        add(1, 1, 0, 1,  1, 0, 0, 0, 0);
        add(1, 1, 1, 4,  1, 1, 0, 0, 0);
        add(0, 1, 1, 1,  0, 0, 0, 0, 0);  // reset mid-grace
        add(1, 1, 0, 1,  1, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            en    = vecs[i].en;
            close = vecs[i].close;
            for (int k = 0; k < vecs[i].n; k++) begin
                @(posedge clk);
                #1;
                chk($sformatf("vec%0d.%0d", i, k), obs(),
                    {vecs[i].ac, vecs[i].grace, vecs[i].lock, vecs[i].eco, vecs[i].cnt});
            end
        end

        // Forced eco shutdowns from RUN; count must stop at all-ones.
        for (int it = 1; it <= 257; it++) begin
            exp_cnt = (it > 255) ? SW'(255) : SW'(it);
            close = 1'b1;
            repeat (GRACE + 1) @(posedge clk);
            #1;
            chk($sformatf("sat_pulse%0d", it), obs(), {1'b0, 1'b0, 1'b1, 1'b1, exp_cnt});
            @(posedge clk);
            #1;
            chk($sformatf("sat_nopulse%0d", it), obs(), {1'b0, 1'b0, 1'b1, 1'b0, exp_cnt});
            repeat (MINOFF - 1) @(posedge clk);
            #1;
            chk($sformatf("sat_off%0d", it), obs(), {1'b0, 1'b0, 1'b0, 1'b0, exp_cnt});
            close = 1'b0;
            @(posedge clk);
            #1;
            chk($sformatf("sat_run%0d", it), obs(), {1'b1, 1'b0, 1'b0, 1'b0, exp_cnt});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
